train_sequencer: RTL and testbench
==================================

Name: train_sequencer

Overview:
- Master state machine for one train segment. Drives the 4-bit present_state code into the time-value selector.
- Loads the selected 19-bit duration (tout) into an internal countdown and advances on expiry, station arrival, or operator and safety events.
- Produces motor, brake and door commands and a trip-complete pulse for the top-level controller.

Parameters:
TW, 19, width of duration value and countdown
SW, 4, width of state code

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  level; request a trip while IDLE
door_closed  in  1  level; doors confirmed shut
station  in  1  level; station-approach sensor
estop  in  1  level; emergency stop
fault_clr  in  1  level; operator fault acknowledge
tick  in  1  timebase strobe, one-cycle pulses
tout  in  TW  duration from selector, combinational function of present_state
present_state  out  SW  current state code, to selector
motor_en  out  1  traction on
brake_en  out  1  brake applied
door_open  out  1  door open command
busy  out  1  state is not IDLE and not FAULT
done  out  1  one-cycle pulse on trip completion
fault  out  1  state is FAULT

Behaviour:
- Reset (async, active-high): state=IDLE, timer=0, load_pend=0, done=0. All outputs take their IDLE values.
- Registered state, 4-bit codes:
  - IDLE=0000
  - ARMED=0001
  - DEPART=0010 (selector supplies t1)
  - CRUISE=0011 (t0)
  - APPROACH=0100 (t0)
  - DWELL=0101 (t0)
  - FAULT=1111
  - Unused codes go to FAULT on the next edge.
- Timer load:
  - Every state change sets load_pend=1 at that edge.
  - On the next edge, timer<=tout and load_pend<=0.
  - When load_pend=0 and timer>0, tick decrements timer by 1. A tick arriving in the load cycle is ignored.
  - No wrap: the timer holds at 0.
- expired = (load_pend==0) && (timer==0), evaluated only in DEPART, CRUISE, APPROACH and DWELL.
- Transitions, one per edge, in priority order:
  1. estop=1 in any state -> FAULT.
  2. FAULT: fault_clr=1 && estop=0 -> IDLE.
  3. IDLE: start=1 -> ARMED.
  4. ARMED: door_closed=1 -> DEPART. Waits indefinitely; no timer.
  5. DEPART: expired -> CRUISE.
  6. CRUISE: station=1 -> APPROACH. If station=0 and expired -> FAULT (overrun timeout). If both happen in the same cycle, station wins.
  7. APPROACH: expired -> DWELL.
  8. DWELL: expired -> IDLE, with done=1 for exactly the cycle after that edge.
  9. door_closed=0 in DEPART, CRUISE or APPROACH -> FAULT.
- Timing: with tick held high, a timed state lasts tout+2 cycles (1 load cycle + tout decrements + 1 decision cycle). tout=0 gives 2 cycles.
- Outputs, registered and decoded from the next state so they align with present_state:
  - motor_en=1 in DEPART and CRUISE.
  - brake_en=1 in IDLE, ARMED, APPROACH, DWELL and FAULT.
  - door_open=1 in IDLE and DWELL.
  - Motor and brake are never both 1.
- Reset asserted mid-trip: immediate return to IDLE with brake on. The timer value is discarded.
- start held high through a trip starts a new trip on the cycle after returning to IDLE.

Decomposition:
- Shared package train_pkg holds:
  - the state-code localparams (IDLE..FAULT), which the selector also uses
  - TW and SW
- One sub-module, seg_timer: loadable down-counter with ports clk, reset, load, tick, din[TW-1:0], zero. It implements the load-priority and saturate-at-0 rules.
- The FSM and output decode stay in train_sequencer.

Test Plan:
- Reset then release, tick=1, start pulse, door_closed=1, tout model t1=3 / t0=2, station=1 asserted during CRUISE -> state sequence 0000, 0001, 0010×5, 0011 (exits on station), 0100×4, 0101×4, 0000. done high one cycle after the DWELL->IDLE edge.
- CRUISE with station=0, t0=2, tick=1 -> FAULT 4 cycles after entry. fault=1 and brake_en=1. fault_clr=1 with estop=0 -> IDLE next edge.
- estop=1 during DEPART with timer=2 -> FAULT next edge, motor_en=0 that same cycle. fault_clr=1 while estop=1 -> stays FAULT.
- tick pulses every 4th cycle, t1=2, tick coincident with the load cycle -> tick ignored. DEPART lasts 1 + 2×4 + 1 cycles (±3 for tick phase); the timer never drops below 0.
- Async reset asserted mid-APPROACH, between clock edges -> present_state=0000, brake_en=1, door_open=1 immediately. After release, no done pulse.
- Same-cycle station=1 and expiry in CRUISE -> APPROACH, not FAULT. tout=0 in DEPART -> CRUISE after exactly 2 cycles.

Source files
------------

// File: rtl/train_pkg.sv
// Shared definitions for the train segment controller: widths, state codes
// (also consumed by the time-value selector) and the per-state output decode.
package train_pkg;

  localparam int TW = 19;
  localparam int SW = 4;

  localparam logic [SW-1:0] IDLE     = 4'b0000;
  localparam logic [SW-1:0] ARMED    = 4'b0001;
  localparam logic [SW-1:0] DEPART   = 4'b0010;
  localparam logic [SW-1:0] CRUISE   = 4'b0011;
  localparam logic [SW-1:0] APPROACH = 4'b0100;
  localparam logic [SW-1:0] DWELL    = 4'b0101;
  localparam logic [SW-1:0] FAULT    = 4'b1111;

  typedef enum logic [SW-1:0] {
    ST_IDLE     = IDLE,
    ST_ARMED    = ARMED,
    ST_DEPART   = DEPART,
    ST_CRUISE   = CRUISE,
    ST_APPROACH = APPROACH,
    ST_DWELL    = DWELL,
    ST_FAULT    = FAULT
  } state_t;

  typedef struct packed {
    logic motor_en;
    logic brake_en;
    logic door_open;
    logic busy;
    logic fault;
  } cmd_t;

  // Motor and brake are decoded from disjoint state sets, so they can never
  // both be asserted.
  function automatic cmd_t decode_cmd(input state_t s);
    cmd_t c;
    c.motor_en  = (s == ST_DEPART) || (s == ST_CRUISE);
    c.brake_en  = !((s == ST_DEPART) || (s == ST_CRUISE));
    c.door_open = (s == ST_IDLE) || (s == ST_DWELL);
    c.busy      = (s != ST_IDLE) && (s != ST_FAULT);
    c.fault     = (s == ST_FAULT);
    return c;
  endfunction

endpackage

// File: rtl/seg_timer.sv
// Loadable down-counter for segment durations. Load beats tick, and the
// count saturates at zero instead of wrapping.
module seg_timer
  import train_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          tick,
  input  logic [TW-1:0] din,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/train_sequencer.sv
// Master state machine for one train segment: sequences a trip, times each
// segment via seg_timer and issues registered motor/brake/door commands.
module train_sequencer
  import train_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          door_closed,
  input  logic          station,
  input  logic          estop,
  input  logic          fault_clr,
  input  logic          tick,
  input  logic [TW-1:0] tout,
  output logic [SW-1:0] present_state,
  output logic          motor_en,
  output logic          brake_en,
  output logic          door_open,
  output logic          busy,
  output logic          done,
  output logic          fault
);

  state_t state;
  state_t next_state;
  logic   load_pend;
  logic   timer_zero;
  logic   expired;
  cmd_t   next_cmd;

  // The timer is loaded in the cycle after every state change, because tout
  // only reflects the new present_state once that state is registered.
  seg_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load_pend),
    .tick  (tick),
    .din   (tout),
    .zero  (timer_zero)
  );

  assign expired = !load_pend && timer_zero;

  always_comb begin
    next_state = state;
    if (estop) begin
      next_state = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE:     if (start) next_state = ST_ARMED;
        ST_ARMED:    if (door_closed) next_state = ST_DEPART;
        ST_DEPART: begin
          if (expired)           next_state = ST_CRUISE;
          else if (!door_closed) next_state = ST_FAULT;
        end
        // Station arrival outranks the overrun timeout.
        ST_CRUISE: begin
          if (station)           next_state = ST_APPROACH;
          else if (expired)      next_state = ST_FAULT;
          else if (!door_closed) next_state = ST_FAULT;
        end
        ST_APPROACH: begin
          if (expired)           next_state = ST_DWELL;
          else if (!door_closed) next_state = ST_FAULT;
        end
        ST_DWELL:    if (expired) next_state = ST_IDLE;
        ST_FAULT:    if (fault_clr) next_state = ST_IDLE;
        default:     next_state = ST_FAULT;
      endcase
    end
  end

  assign next_cmd = decode_cmd(next_state);

  // done is a single-cycle strobe with no handshake: it is high for exactly
  // the cycle following the DWELL->IDLE edge and the consumer must sample it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      load_pend <= 1'b0;
      done      <= 1'b0;
      motor_en  <= 1'b0;
      brake_en  <= 1'b1;
      door_open <= 1'b1;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= next_state;
      load_pend <= (next_state != state);
      done      <= (state == ST_DWELL) && (next_state == ST_IDLE);
      motor_en  <= next_cmd.motor_en;
      brake_en  <= next_cmd.brake_en;
      door_open <= next_cmd.door_open;
      busy      <= next_cmd.busy;
      fault     <= next_cmd.fault;
    end
  end

  assign present_state = state;

endmodule

// File: tb/tb_train_sequencer.sv
// Directed testbench for train_sequencer: the driver pushes the expected
// per-cycle outputs into a queue, a negedge monitor pops and compares.
module tb_train_sequencer;
  import train_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          door_closed;
  logic          station;
  logic          estop;
  logic          fault_clr;
  logic          tick;
  logic [TW-1:0] tout;
  logic [TW-1:0] t1_val;
  logic [TW-1:0] t0_val;
  logic [SW-1:0] present_state;
  logic          motor_en;
  logic          brake_en;
  logic          door_open;
  logic          busy;
  logic          done;
  logic          fault;

  logic [9:0] exp_q[$];
  string      tag_q[$];
  string      tag;
  logic [9:0] mon_exp;
  logic [9:0] mon_act;
  string      mon_tag;
  int         n_tests = 0;
  int         n_fail  = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Time-value selector model: t1 in DEPART, t0 everywhere else.
  assign tout = (present_state == DEPART) ? t1_val : t0_val;

  train_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .door_closed   (door_closed),
    .station       (station),
    .estop         (estop),
    .fault_clr     (fault_clr),
    .tick          (tick),
    .tout          (tout),
    .present_state (present_state),
    .motor_en      (motor_en),
    .brake_en      (brake_en),
    .door_open     (door_open),
    .busy          (busy),
    .done          (done),
    .fault         (fault)
  );

  // Expected output vector {state, motor, brake, door, busy, done, fault}.
  function automatic logic [9:0] exp_vec(input logic [SW-1:0] st, input logic dn);
    logic mot, brk, dor, bsy, flt;
    mot = (st == DEPART) || (st == CRUISE);
    brk = (st == IDLE) || (st == ARMED) || (st == APPROACH) || (st == DWELL) || (st == FAULT);
    dor = (st == IDLE) || (st == DWELL);
    bsy = (st != IDLE) && (st != FAULT);
    flt = (st == FAULT);
    return {st, mot, brk, dor, bsy, dn, flt};
  endfunction

  // driver tasks
  task automatic step(input logic [SW-1:0] st, input logic dn);
    @(posedge clk);
    #1;
    exp_q.push_back(exp_vec(st, dn));
    tag_q.push_back(tag);
  endtask

  task automatic steps(input logic [SW-1:0] st, input int n);
    for (int i = 0; i < n; i++) step(st, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {present_state, motor_en, brake_en, door_open, busy, done, fault};
      n_tests++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got state=%b m/b/d/busy/done/fault=%b, expected state=%b m/b/d/busy/done/fault=%b",
                 mon_tag, mon_act[9:6], mon_act[5:0], mon_exp[9:6], mon_exp[5:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; door_closed = 1'b1; station = 1'b0;
    estop = 1'b0; fault_clr = 1'b0; tick = 1'b1;
    t1_val = 19'd3; t0_val = 19'd2;
    tag = "reset";
    repeat (2) @(posedge clk);
    step(IDLE, 1'b0);
    reset = 1'b0;

    // Full trip: DEPART 3+2, CRUISE exits on station, APPROACH/DWELL 2+2.
    tag = "trip";
    start = 1'b1;
    step(ARMED, 1'b0);
    start = 1'b0;
    steps(DEPART, 5);
    station = 1'b1;
    step(CRUISE, 1'b0);
    step(APPROACH, 1'b0);
    station = 1'b0;
    steps(APPROACH, 3);
    steps(DWELL, 4);
    step(IDLE, 1'b1);
    step(IDLE, 1'b0);

    // CRUISE overrun: no station, timeout after t0+2 cycles.
    tag = "overrun";
    start = 1'b1;
    step(ARMED, 1'b0);
    start = 1'b0;
    steps(DEPART, 5);
    steps(CRUISE, 4);
    step(FAULT, 1'b0);
    step(FAULT, 1'b0);
    fault_clr = 1'b1;
    step(IDLE, 1'b0);
    fault_clr = 1'b0;

    // estop in DEPART with timer=2; clear is blocked while estop stays high.
    tag = "estop";
    start = 1'b1;
    step(ARMED, 1'b0);
    start = 1'b0;
    steps(DEPART, 3);
    estop = 1'b1;
    step(FAULT, 1'b0);
    fault_clr = 1'b1;
    steps(FAULT, 2);
    estop = 1'b0;
    step(IDLE, 1'b0);
    fault_clr = 1'b0;

    // Sparse ticks, t1=2: load-cycle tick ignored, ticks at edges 5 and 9.
    tag = "sparse_tick";
    t1_val = 19'd2;
    tick = 1'b0;
    start = 1'b1;
    step(ARMED, 1'b0);
    start = 1'b0;
    step(DEPART, 1'b0);
    for (int i = 1; i < 10; i++) begin
      tick = (i % 4 == 1);
      step(DEPART, 1'b0);
    end
    tick = 1'b0;
    step(CRUISE, 1'b0);
    tick = 1'b1;
    station = 1'b1;
    step(APPROACH, 1'b0);
    station = 1'b0;
    step(APPROACH, 1'b0);

    // Async reset between clock edges, mid-APPROACH.
    tag = "async_reset";
    @(posedge clk);
    #4;
    reset = 1'b1;
    exp_q.push_back(exp_vec(IDLE, 1'b0));
    tag_q.push_back(tag);
    steps(IDLE, 2);
    reset = 1'b0;
    tag = "no_done_after_reset";
    steps(IDLE, 3);

    // tout=0 in DEPART, then station coincident with CRUISE expiry.
    tag = "tout_zero";
    t1_val = 19'd0;
    start = 1'b1;
    step(ARMED, 1'b0);
    start = 1'b0;
    steps(DEPART, 2);
    tag = "station_vs_expiry";
    steps(CRUISE, 4);
    station = 1'b1;
    step(APPROACH, 1'b0);
    station = 1'b0;
    start = 1'b1;
    steps(APPROACH, 3);
    steps(DWELL, 4);
    tag = "start_held";
    step(IDLE, 1'b1);
    step(ARMED, 1'b0);
    start = 1'b0;
    step(DEPART, 1'b0);
    tag = "door_open";
    door_closed = 1'b0;
    step(FAULT, 1'b0);
    door_closed = 1'b1;
    fault_clr = 1'b1;
    step(IDLE, 1'b0);
    fault_clr = 1'b0;

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
